// File: rtl/image_io_pkg.sv
// Shared definitions for the result capture path: register offsets, STATUS
// bit positions, capture FSM encoding and the AXI response code.
package image_io_pkg;

  // Byte offsets within the AXI-Lite window (bits [1:0] are ignored on decode)
  localparam int RES_BUF_BASE = 'h000;
  localparam int RES_STATUS   = 'h100;
  localparam int RES_CONTROL  = 'h104;
  localparam int RES_ARGMAX   = 'h108;

  // STATUS register layout
  localparam int STATUS_DONE_BIT  = 0;
  localparam int STATUS_BUSY_BIT  = 1;
  localparam int STATUS_SHORT_BIT = 2;
  localparam int STATUS_COUNT_LSB = 8;

  // Capture FSM encoding
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } cap_state_e;

  // AXI response code; every access completes with OKAY
  localparam logic [1:0] OKAY = 2'b00;

endpackage

// File: rtl/axil_slave_regif.sv
// AXI4-Lite slave channel handling. Turns an accepted write into a one-cycle
// wr_en/wr_addr/wr_data strobe and serves reads through a combinational
// rd_addr -> rd_data lookup supplied by the parent.
//
// Handshake rule on every channel: a transfer happens on a rising clock edge
// where valid and ready are both high; the master holds valid and payload
// stable until then, and the slave holds bvalid/rvalid and their payload
// stable until the matching ready is seen.
module axil_slave_regif
  import image_io_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  // write address / data / response
  input  logic [ADDR_W-1:0] awaddr_i,
  input  logic              awvalid_i,
  output logic              awready_o,
  input  logic [31:0]       wdata_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  output logic [1:0]        bresp_o,
  output logic              bvalid_o,
  input  logic              bready_i,
  // read address / data
  input  logic [ADDR_W-1:0] araddr_i,
  input  logic              arvalid_i,
  output logic              arready_o,
  output logic [31:0]       rdata_o,
  output logic [1:0]        rresp_o,
  output logic              rvalid_o,
  input  logic              rready_i,
  // register-side interface
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [31:0]       rd_data_i
);

  logic        wr_rdy_q;
  logic        bvalid_q;
  logic        ar_rdy_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic        ar_hs;

  // One ready register drives both AW and W so the two are always taken together
  assign awready_o = wr_rdy_q;
  assign wready_o  = wr_rdy_q;
  assign bvalid_o  = bvalid_q;
  assign bresp_o   = OKAY;
  assign arready_o = ar_rdy_q;
  assign rvalid_o  = rvalid_q;
  assign rdata_o   = rdata_q;
  assign rresp_o   = OKAY;

  assign wr_en_o   = wr_rdy_q & awvalid_i & wvalid_i;
  assign wr_addr_o = awaddr_i;
  assign wr_data_o = wdata_i;
  assign rd_addr_o = araddr_i;
  assign ar_hs     = ar_rdy_q & arvalid_i;

  // Write path: pulse ready once per address+data pair, then hold bvalid until bready
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_rdy_q <= 1'b0;
      bvalid_q <= 1'b0;
    end else begin
      wr_rdy_q <= !wr_rdy_q && awvalid_i && wvalid_i && !bvalid_q;
      if (wr_en_o) begin
        bvalid_q <= 1'b1;
      end else if (bready_i) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Read path: pulse arready, latch the lookup, hold rvalid/rdata until rready
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ar_rdy_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      ar_rdy_q <= !ar_rdy_q && arvalid_i && !rvalid_q;
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data_i;
      end else if (rready_i) begin
        rvalid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/result_capture_module.sv
// Result capture: accepts the network's output vector from an AXI-Stream
// input into a DEPTH-word buffer and exposes buffer, STATUS, CONTROL (and
// optionally a running argmax) over AXI4-Lite.
// Optional feature macro: RESULT_ARGMAX_EN (argmax index readable at 0x108).
module result_capture_module
  import image_io_pkg::*;
#(
  parameter int DEPTH  = 10,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  input  logic              start,
  input  logic [DATA_W-1:0] y_tdata,
  input  logic              y_tvalid,
  output logic              y_tready,
  input  logic              y_tlast,
  output logic              done,
  input  logic [ADDR_W-1:0] S_AXI_awaddr,
  input  logic [2:0]        S_AXI_awprot,
  input  logic              S_AXI_awvalid,
  output logic              S_AXI_awready,
  input  logic [31:0]       S_AXI_wdata,
  input  logic [3:0]        S_AXI_wstrb,
  input  logic              S_AXI_wvalid,
  output logic              S_AXI_wready,
  output logic [1:0]        S_AXI_bresp,
  output logic              S_AXI_bvalid,
  input  logic              S_AXI_bready,
  input  logic [ADDR_W-1:0] S_AXI_araddr,
  input  logic [2:0]        S_AXI_arprot,
  input  logic              S_AXI_arvalid,
  output logic              S_AXI_arready,
  output logic [31:0]       S_AXI_rdata,
  output logic [1:0]        S_AXI_rresp,
  output logic              S_AXI_rvalid,
  input  logic              S_AXI_rready
);

  // count reaches DEPTH (max 64), so 7 bits
  localparam int CNT_W = 7;

  cap_state_e        state_q;
  logic [CNT_W-1:0]  count_q;
  logic              done_q;
  logic              short_q;
  logic [DATA_W-1:0] res_buf_q [DEPTH];

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;
  logic [ADDR_W-3:0] wr_word;
  logic [ADDR_W-3:0] rd_word;
  logic              arm;
  logic              hs;
  logic              last_slot;
  logic [31:0]       status_word;
  logic [31:0]       argmax_rd;
  logic              unused_ok;

  axil_slave_regif #(.ADDR_W(ADDR_W)) u_regif (
    .clk_i     (s_axi_aclk),
    .rst_n_i   (s_axi_aresetn),
    .awaddr_i  (S_AXI_awaddr),
    .awvalid_i (S_AXI_awvalid),
    .awready_o (S_AXI_awready),
    .wdata_i   (S_AXI_wdata),
    .wvalid_i  (S_AXI_wvalid),
    .wready_o  (S_AXI_wready),
    .bresp_o   (S_AXI_bresp),
    .bvalid_o  (S_AXI_bvalid),
    .bready_i  (S_AXI_bready),
    .araddr_i  (S_AXI_araddr),
    .arvalid_i (S_AXI_arvalid),
    .arready_o (S_AXI_arready),
    .rdata_o   (S_AXI_rdata),
    .rresp_o   (S_AXI_rresp),
    .rvalid_o  (S_AXI_rvalid),
    .rready_i  (S_AXI_rready),
    .wr_en_o   (wr_en),
    .wr_addr_o (wr_addr),
    .wr_data_o (wr_data),
    .rd_addr_o (rd_addr),
    .rd_data_i (rd_data)
  );

  // Protection bits, byte strobes and sub-word address bits carry no meaning here
  assign unused_ok = ^{S_AXI_awprot, S_AXI_arprot, S_AXI_wstrb,
                       wr_addr[1:0], rd_addr[1:0], wr_data[31:1]};

  assign wr_word   = wr_addr[ADDR_W-1:2];
  assign rd_word   = rd_addr[ADDR_W-1:2];
  assign arm       = start || (wr_en && (int'(wr_word) == RES_CONTROL / 4) && wr_data[0]);
  assign y_tready  = (state_q == CAPTURE);
  assign hs        = y_tvalid && y_tready;
  assign last_slot = (count_q == CNT_W'(DEPTH - 1));
  assign done      = done_q;

  // Capture FSM with count, done and short flag; arm overrides a same-cycle beat
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
      short_q <= 1'b0;
    end else if (arm) begin
      state_q <= CAPTURE;
      count_q <= '0;
      done_q  <= 1'b0;
      short_q <= 1'b0;
    end else if (hs) begin
      count_q <= count_q + 1'b1;
      if (last_slot || y_tlast) begin
        state_q <= DONE;
        done_q  <= 1'b1;
        short_q <= !last_slot;
      end
    end
  end

  // Buffer write on each accepted beat; arm keeps old contents for later overwrite
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      for (int i = 0; i < DEPTH; i++) res_buf_q[i] <= '0;
    end else if (hs && !arm) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (count_q == CNT_W'(i)) res_buf_q[i] <= y_tdata;
      end
    end
  end

`ifdef RESULT_ARGMAX_EN
  logic [7:0]               amax_idx_q;
  logic signed [DATA_W-1:0] amax_val_q;

  // Running argmax; only a strictly greater value moves it, so ties keep the lowest index
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn || arm) begin
      amax_idx_q <= '0;
      amax_val_q <= '0;
    end else if (hs) begin
      if (count_q == '0 || $signed(y_tdata) > amax_val_q) begin
        amax_idx_q <= {1'b0, count_q};
        amax_val_q <= $signed(y_tdata);
      end
    end
  end

  assign argmax_rd = {24'b0, amax_idx_q};
`else
  assign argmax_rd = '0;
`endif

  // STATUS word assembly
  always_comb begin
    status_word = '0;
    status_word[STATUS_DONE_BIT]         = done_q;
    status_word[STATUS_BUSY_BIT]         = (state_q == CAPTURE);
    status_word[STATUS_SHORT_BIT]        = short_q;
    status_word[STATUS_COUNT_LSB +: 8]   = {1'b0, count_q};
  end

  // Read decode; CONTROL and unmapped words read as zero
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(rd_word) == RES_BUF_BASE / 4 + i) rd_data = res_buf_q[i];
    end
    if (int'(rd_word) == RES_STATUS / 4) rd_data = status_word;
    if (int'(rd_word) == RES_ARGMAX / 4) rd_data = argmax_rd;
  end

endmodule

// File: tb/tb_result_capture_module.sv
// Bench for result_capture_module: stream driver, AXI-Lite driver tasks, a
// buffer model filled from the driven beats, and an expected-value queue
// popped as AXI reads complete.
module tb_result_capture_module;

  localparam int DEPTH = 10;

  logic        s_axi_aclk = 1'b0;
  logic        s_axi_aresetn;
  logic        start;
  logic [31:0] y_tdata;
  logic        y_tvalid;
  logic        y_tready;
  logic        y_tlast;
  logic        done;
  logic [11:0] S_AXI_awaddr;
  logic [2:0]  S_AXI_awprot;
  logic        S_AXI_awvalid;
  logic        S_AXI_awready;
  logic [31:0] S_AXI_wdata;
  logic [3:0]  S_AXI_wstrb;
  logic        S_AXI_wvalid;
  logic        S_AXI_wready;
  logic [1:0]  S_AXI_bresp;
  logic        S_AXI_bvalid;
  logic        S_AXI_bready;
  logic [11:0] S_AXI_araddr;
  logic [2:0]  S_AXI_arprot;
  logic        S_AXI_arvalid;
  logic        S_AXI_arready;
  logic [31:0] S_AXI_rdata;
  logic [1:0]  S_AXI_rresp;
  logic        S_AXI_rvalid;
  logic        S_AXI_rready;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_buf [DEPTH];
  int          model_cnt = 0;
  logic [31:0] rd_tmp;
  logic [31:0] amax_vals [DEPTH];

  result_capture_module #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(12)) dut (
    .s_axi_aclk    (s_axi_aclk),
    .s_axi_aresetn (s_axi_aresetn),
    .start         (start),
    .y_tdata       (y_tdata),
    .y_tvalid      (y_tvalid),
    .y_tready      (y_tready),
    .y_tlast       (y_tlast),
    .done          (done),
    .S_AXI_awaddr  (S_AXI_awaddr),
    .S_AXI_awprot  (S_AXI_awprot),
    .S_AXI_awvalid (S_AXI_awvalid),
    .S_AXI_awready (S_AXI_awready),
    .S_AXI_wdata   (S_AXI_wdata),
    .S_AXI_wstrb   (S_AXI_wstrb),
    .S_AXI_wvalid  (S_AXI_wvalid),
    .S_AXI_wready  (S_AXI_wready),
    .S_AXI_bresp   (S_AXI_bresp),
    .S_AXI_bvalid  (S_AXI_bvalid),
    .S_AXI_bready  (S_AXI_bready),
    .S_AXI_araddr  (S_AXI_araddr),
    .S_AXI_arprot  (S_AXI_arprot),
    .S_AXI_arvalid (S_AXI_arvalid),
    .S_AXI_arready (S_AXI_arready),
    .S_AXI_rdata   (S_AXI_rdata),
    .S_AXI_rresp   (S_AXI_rresp),
    .S_AXI_rvalid  (S_AXI_rvalid),
    .S_AXI_rready  (S_AXI_rready)
  );

  // Clock
  always #5 s_axi_aclk = ~s_axi_aclk;

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge s_axi_aclk);
    #1;
  endtask

  task automatic arm_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_cnt = 0;
  endtask

  // Drive one beat and return right after the edge that accepted it
  task automatic send_beat(input logic [31:0] data, input logic last, input bit gap);
    int w;
    if (gap) begin
      y_tvalid = 1'b0;
      tick();
    end
    y_tdata  = data;
    y_tlast  = last;
    y_tvalid = 1'b1;
    w = 0;
    while (!y_tready && w < 50) begin
      tick();
      w++;
    end
    if (!y_tready) begin
      check("tready_timeout", {31'b0, y_tready}, 32'd1);
    end else begin
      tick();
      model_buf[model_cnt] = data;
      model_cnt++;
    end
  endtask

  task automatic axi_read(input logic [11:0] addr, output logic [31:0] data);
    int w;
    S_AXI_araddr  = addr;
    S_AXI_arvalid = 1'b1;
    w = 0;
    while (!S_AXI_arready && w < 50) begin
      tick();
      w++;
    end
    if (!S_AXI_arready) check("arready_timeout", {31'b0, S_AXI_arready}, 32'd1);
    tick();
    S_AXI_arvalid = 1'b0;
    w = 0;
    while (!S_AXI_rvalid && w < 50) begin
      tick();
      w++;
    end
    if (!S_AXI_rvalid) check("rvalid_timeout", {31'b0, S_AXI_rvalid}, 32'd1);
    data = S_AXI_rdata;
    check("rresp", {30'b0, S_AXI_rresp}, 32'd0);
    S_AXI_rready = 1'b1;
    tick();
    S_AXI_rready = 1'b0;
  endtask

  task automatic read_expect(input logic [11:0] addr, input logic [31:0] exp, input string tag);
    logic [31:0] d;
    exp_q.push_back(exp);
    axi_read(addr, d);
    check(tag, d, exp_q.pop_front());
  endtask

  task automatic axi_write(input logic [11:0] addr, input logic [31:0] data, input int hold);
    int w;
    S_AXI_awaddr  = addr;
    S_AXI_wdata   = data;
    S_AXI_wstrb   = 4'hF;
    S_AXI_awvalid = 1'b1;
    S_AXI_wvalid  = 1'b1;
    w = 0;
    while (!S_AXI_awready && w < 50) begin
      tick();
      w++;
    end
    if (!S_AXI_awready) check("awready_timeout", {31'b0, S_AXI_awready}, 32'd1);
    check("wready_with_awready", {31'b0, S_AXI_wready}, 32'd1);
    tick();
    S_AXI_awvalid = 1'b0;
    S_AXI_wvalid  = 1'b0;
    w = 0;
    while (!S_AXI_bvalid && w < 50) begin
      tick();
      w++;
    end
    if (!S_AXI_bvalid) check("bvalid_timeout", {31'b0, S_AXI_bvalid}, 32'd1);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("bvalid_hold", {31'b0, S_AXI_bvalid}, 32'd1);
    end
    check("bresp", {30'b0, S_AXI_bresp}, 32'd0);
    S_AXI_bready = 1'b1;
    tick();
    S_AXI_bready = 1'b0;
    check("bvalid_clear", {31'b0, S_AXI_bvalid}, 32'd0);
  endtask

  task automatic verify_buf(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      read_expect(12'(4 * i), model_buf[i], tag);
    end
  endtask

  initial begin
    amax_vals = '{32'hFFFF_FFFB, 32'd7, 32'd3, 32'd7, 32'hFFFF_FFFF,
                  32'd0, 32'd2, 32'd6, 32'd1, 32'd4};
    for (int i = 0; i < DEPTH; i++) model_buf[i] = '0;
    s_axi_aresetn = 1'b0;
    start = 1'b0;
    y_tdata = '0; y_tvalid = 1'b0; y_tlast = 1'b0;
    S_AXI_awaddr = '0; S_AXI_awprot = '0; S_AXI_awvalid = 1'b0;
    S_AXI_wdata = '0; S_AXI_wstrb = '0; S_AXI_wvalid = 1'b0; S_AXI_bready = 1'b0;
    S_AXI_araddr = '0; S_AXI_arprot = '0; S_AXI_arvalid = 1'b0; S_AXI_rready = 1'b0;

    // Reset: all outputs idle
    repeat (30) tick();
    check("rst_tready", {31'b0, y_tready}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_ready_valids", {27'b0, S_AXI_awready, S_AXI_wready, S_AXI_bvalid,
                               S_AXI_arready, S_AXI_rvalid}, 32'd0);
    check("rst_rdata", S_AXI_rdata, 32'd0);
    check("rst_resp", {28'b0, S_AXI_bresp, S_AXI_rresp}, 32'd0);
    s_axi_aresetn = 1'b1;
    tick();
    read_expect(12'h100, 32'h0000_0000, "rst_status");
    read_expect(12'h000, 32'h0000_0000, "rst_buf0");

    // Full vector, continuous valid, no tlast
    arm_start();
    check("arm_tready", {31'b0, y_tready}, 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      send_beat(32'(i + 1), 1'b0, 1'b0);
      if (i == DEPTH - 2) check("done_before_last", {31'b0, done}, 32'd0);
    end
    check("full_done", {31'b0, done}, 32'd1);
    check("full_tready_low", {31'b0, y_tready}, 32'd0);
    // Overlong: upstream keeps offering, nothing is accepted
    y_tdata = 32'hEEEE_EEEE;
    repeat (4) tick();
    check("overlong_tready", {31'b0, y_tready}, 32'd0);
    y_tvalid = 1'b0;
    verify_buf("full_buf");
    read_expect(12'h100, 32'h0000_0A01, "full_status");

    // Toggled valid, armed by CONTROL write
    axi_write(12'h104, 32'h1, 2);
    model_cnt = 0;
    for (int i = 0; i < DEPTH; i++) send_beat(32'h100 + 32'(i), 1'b0, 1'b1);
    y_tvalid = 1'b0;
    check("gap_done", {31'b0, done}, 32'd1);
    verify_buf("gap_buf");
    read_expect(12'h100, 32'h0000_0A01, "gap_status");

    // Short vector: tlast on the 4th beat
    arm_start();
    for (int i = 0; i < 4; i++) send_beat(32'h200 + 32'(i), (i == 3), 1'b0);
    y_tvalid = 1'b0;
    y_tlast  = 1'b0;
    check("short_done", {31'b0, done}, 32'd1);
    read_expect(12'h100, 32'h0000_0405, "short_status");
    verify_buf("short_buf");

    // CONTROL arm colliding with a beat handshake
    arm_start();
    send_beat(32'h300, 1'b0, 1'b0);
    send_beat(32'h301, 1'b0, 1'b0);
    y_tvalid = 1'b0;
    S_AXI_awaddr = 12'h104; S_AXI_wdata = 32'h1; S_AXI_wstrb = 4'hF;
    S_AXI_awvalid = 1'b1; S_AXI_wvalid = 1'b1;
    for (int w = 0; w < 50 && !S_AXI_awready; w++) tick();
    check("coll_awready", {31'b0, S_AXI_awready}, 32'd1);
    y_tdata = 32'hBAD; y_tvalid = 1'b1; y_tlast = 1'b0;
    check("coll_tready", {31'b0, y_tready}, 32'd1);
    tick();
    y_tvalid = 1'b0; S_AXI_awvalid = 1'b0; S_AXI_wvalid = 1'b0;
    model_cnt = 0;
    for (int w = 0; w < 50 && !S_AXI_bvalid; w++) tick();
    check("coll_bvalid", {31'b0, S_AXI_bvalid}, 32'd1);
    S_AXI_bready = 1'b1;
    tick();
    S_AXI_bready = 1'b0;
    read_expect(12'h100, 32'h0000_0002, "coll_status");
    send_beat(32'h355, 1'b1, 1'b0);
    y_tvalid = 1'b0;
    y_tlast  = 1'b0;
    read_expect(12'h100, 32'h0000_0105, "coll_status2");
    verify_buf("coll_buf");

    // Unmapped read, ignored writes to buffer and STATUS
    read_expect(12'h1FC, 32'h0, "unmapped_read");
    axi_write(12'h000, 32'hDEAD_BEEF, 3);
    read_expect(12'h000, model_buf[0], "buf_write_ignored");
    axi_write(12'h100, 32'hFFFF_FFFF, 0);
    read_expect(12'h100, 32'h0000_0105, "status_write_ignored");
    read_expect(12'h104, 32'h0, "control_reads_zero");

    // Argmax vector (ties keep the lowest index)
    arm_start();
    for (int i = 0; i < DEPTH; i++) send_beat(amax_vals[i], 1'b0, (i % 3 == 1));
    y_tvalid = 1'b0;
    check("amax_done", {31'b0, done}, 32'd1);
`ifdef RESULT_ARGMAX_EN
    read_expect(12'h108, 32'd1, "argmax");
`else
    read_expect(12'h108, 32'd0, "argmax_absent");
`endif
    verify_buf("amax_buf");

    // Reset mid-capture clears everything
    arm_start();
    for (int i = 0; i < 3; i++) send_beat(32'h400 + 32'(i), 1'b0, 1'b0);
    y_tvalid = 1'b0;
    s_axi_aresetn = 1'b0;
    tick();
    tick();
    s_axi_aresetn = 1'b1;
    for (int i = 0; i < DEPTH; i++) model_buf[i] = '0;
    check("midrst_tready", {31'b0, y_tready}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    tick();
    read_expect(12'h100, 32'h0000_0000, "midrst_status");
    verify_buf("midrst_buf");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
